axi_rd_arbiter: RTL and testbench

Shares the single AXI read address/data channel pair between the instruction-cache refill port and the data-cache refill/uncached-read port. It sits between both caches and the AXI bridge. It keeps at most one read transaction outstanding and runs a three-state sequencer: grant, address phase, data phase. Returned beats are steered to the requester that owns the transaction.

---
 rtl/axi_rd_arbiter_pkg.sv | 21 ++
 rtl/axi_rd_arbiter_pick.sv | 36 +++
 rtl/axi_rd_arbiter.sv | 157 +++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arbiter_pkg.sv
// Shared encodings for the AXI read arbiter: request types, AXI IDs, burst type and
// sequencer states.
package axi_rd_arbiter_pkg;

    localparam logic [2:0] RD_TYPE_BYTE = 3'b000;
    localparam logic [2:0] RD_TYPE_HALF = 3'b001;
    localparam logic [2:0] RD_TYPE_WORD = 3'b010;
    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

    localparam logic [3:0] ARID_INST = 4'd0;
    localparam logic [3:0] ARID_DATA = 4'd1;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

endpackage

// File: rtl/axi_rd_arbiter_pick.sv
// Grant selection between icache and dcache read requests (grant[0]=inst, grant[1]=data).
// AXI_ARB_RR_EN selects round-robin on the pointer; otherwise data has fixed priority.
module axi_rd_arb_pick (
    input  logic       inst_req,
    input  logic       data_req,
    input  logic       ptr,
    output logic [1:0] grant
);

`ifdef AXI_ARB_RR_EN
    // ptr: 0 prefers inst, 1 prefers data; only consulted when both request
    always_comb begin
        grant = 2'b00;
        if (inst_req && data_req) begin
            grant = ptr ? 2'b10 : 2'b01;
        end else if (data_req) begin
            grant = 2'b10;
        end else if (inst_req) begin
            grant = 2'b01;
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ptr;

    always_comb begin
        grant = 2'b00;
        if (data_req) begin
            grant = 2'b10;
        end else if (inst_req) begin
            grant = 2'b01;
        end
    end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between icache and dcache, one transaction outstanding.
// Build option AXI_ARB_RR_EN enables round-robin arbitration instead of data-first.
//
// state  | meaning
// S_IDLE | ready to accept the selected requester
// S_ADDR | arvalid asserted with latched fields, waiting for arready
// S_DATA | rready asserted, beats steered to the owner until rlast
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_rd_req,
    input  logic [2:0]  inst_rd_type,
    input  logic [31:0] inst_rd_addr,
    output logic        inst_rd_rdy,
    output logic        inst_ret_valid,
    output logic        inst_ret_last,
    output logic [31:0] inst_ret_data,

    input  logic        data_rd_req,
    input  logic [2:0]  data_rd_type,
    input  logic [31:0] data_rd_addr,
    output logic        data_rd_rdy,
    output logic        data_ret_valid,
    output logic        data_ret_last,
    output logic [31:0] data_ret_data,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    state_t      state, state_nxt;
    logic [1:0]  grant;
    logic        accept;
    logic        rr_ptr;
    logic        owner_data;
    logic        lat_line;
    logic [1:0]  lat_size;
    logic [31:0] lat_addr;
    logic [2:0]  sel_type;
    logic [1:0]  beat_cnt;
    logic        beat_fwd;

    axi_rd_arb_pick u_pick (
        .inst_req (inst_rd_req),
        .data_req (data_rd_req),
        .ptr      (rr_ptr),
        .grant    (grant)
    );

    assign accept   = (state == S_IDLE) && (grant != 2'b00);
    assign sel_type = grant[1] ? data_rd_type : inst_rd_type;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)          state_nxt = S_ADDR;
            S_ADDR:  if (arready)         state_nxt = S_DATA;
            S_DATA:  if (rvalid && rlast) state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_data <= 1'b0;
            lat_line   <= 1'b0;
            lat_size   <= 2'd0;
            lat_addr   <= 32'd0;
        end else if (accept) begin
            owner_data <= grant[1];
            lat_line   <= (sel_type == RD_TYPE_LINE);
            lat_size   <= sel_type[1:0];
            lat_addr   <= grant[1] ? data_rd_addr : inst_rd_addr;
        end
    end

`ifdef AXI_ARB_RR_EN
    // After a grant the other requester becomes the preferred one
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= grant[0];
        end
    end
`else
    assign rr_ptr = 1'b0;
`endif

    // Debug beat counter; rlast alone ends the burst
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat_cnt <= 2'd0;
        end else if (state == S_IDLE) begin
            beat_cnt <= 2'd0;
        end else if (beat_fwd) begin
            beat_cnt <= beat_cnt + 2'd1;
        end
    end

    a_beat_within_len: assert property (@(posedge clk) disable iff (!resetn)
        beat_fwd |-> (beat_cnt <= arlen[1:0]));

    assign inst_rd_rdy = resetn && (state == S_IDLE) && grant[0];
    assign data_rd_rdy = resetn && (state == S_IDLE) && grant[1];

    assign arid    = owner_data ? ARID_DATA : ARID_INST;
    assign araddr  = lat_addr;
    assign arlen   = lat_line ? 8'd3 : 8'd0;
    assign arsize  = lat_line ? 3'd2 : {1'b0, lat_size};
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = (state == S_ADDR);
    assign rready  = (state == S_DATA);

    assign beat_fwd = rready && rvalid;

    assign inst_ret_valid = beat_fwd && !owner_data;
    assign inst_ret_last  = inst_ret_valid && rlast;
    assign inst_ret_data  = inst_ret_valid ? rdata : 32'd0;

    assign data_ret_valid = beat_fwd && owner_data;
    assign data_ret_last  = data_ret_valid && rlast;
    assign data_ret_data  = data_ret_valid ? rdata : 32'd0;

    logic unused_bits;
    assign unused_bits = ^{rid, rresp};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: table vectors, hand-written corner sequences
// and randomized transactions checked against a transaction-level arbitration model.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_rd_req = 1'b0;
    logic [2:0]  inst_rd_type = 3'd0;
    logic [31:0] inst_rd_addr = 32'd0;
    logic        inst_rd_rdy, inst_ret_valid, inst_ret_last;
    logic [31:0] inst_ret_data;
    logic        data_rd_req = 1'b0;
    logic [2:0]  data_rd_type = 3'd0;
    logic [31:0] data_rd_addr = 32'd0;
    logic        data_rd_rdy, data_ret_valid, data_ret_last;
    logic [31:0] data_ret_data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [3:0]  rid = 4'd0;
    logic [31:0] rdata = 32'd0;
    logic [1:0]  rresp = 2'd0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;

    int n_tests = 0;
    int n_fail  = 0;
    bit model_ptr = 1'b0;   // 0 prefers inst, 1 prefers data

    always #5 clk = ~clk;

    axi_rd_arbiter dut (
        .clk(clk), .resetn(resetn),
        .inst_rd_req(inst_rd_req), .inst_rd_type(inst_rd_type), .inst_rd_addr(inst_rd_addr),
        .inst_rd_rdy(inst_rd_rdy), .inst_ret_valid(inst_ret_valid),
        .inst_ret_last(inst_ret_last), .inst_ret_data(inst_ret_data),
        .data_rd_req(data_rd_req), .data_rd_type(data_rd_type), .data_rd_addr(data_rd_addr),
        .data_rd_rdy(data_rd_rdy), .data_ret_valid(data_ret_valid),
        .data_ret_last(data_ret_last), .data_ret_data(data_ret_data),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_len(input logic [2:0] typ);
        return (typ == 3'b100) ? 8'd3 : 8'd0;
    endfunction

    function automatic logic [2:0] exp_size(input logic [2:0] typ);
        return (typ == 3'b100) ? 3'd2 : {1'b0, typ[1:0]};
    endfunction

    function automatic bit model_winner();
`ifdef AXI_ARB_RR_EN
        return model_ptr;
`else
        return 1'b1;
`endif
    endfunction

    // One full transaction for requester own (1=data). With at_edge set the caller is
    // already positioned at the negedge of the accepting cycle with the request raised.
    task automatic do_txn(input bit own, input logic [2:0] typ, input logic [31:0] addr,
                          input logic [7:0] elen, input logic [2:0] esize,
                          input int ar_wait, input int gap, input logic [31:0] base,
                          input bit at_edge,
                          input bit oth_en, input logic [2:0] oth_typ, input logic [31:0] oth_addr);
        int nb;
        logic oth_req;
        nb = int'(elen) + 1;
        if (!at_edge) @(negedge clk);
        if (own) begin
            data_rd_req = 1'b1; data_rd_type = typ; data_rd_addr = addr;
            if (oth_en) begin inst_rd_req = 1'b1; inst_rd_type = oth_typ; inst_rd_addr = oth_addr; end
        end else begin
            inst_rd_req = 1'b1; inst_rd_type = typ; inst_rd_addr = addr;
            if (oth_en) begin data_rd_req = 1'b1; data_rd_type = oth_typ; data_rd_addr = oth_addr; end
        end
        #1;
        chk("rdy_own_idle", own ? data_rd_rdy : inst_rd_rdy, 1);
        chk("rdy_oth_idle", own ? inst_rd_rdy : data_rd_rdy, 0);
        @(posedge clk); #1;
        if (own) data_rd_req = 1'b0; else inst_rd_req = 1'b0;
        for (int w = 0; w <= ar_wait; w++) begin
            @(negedge clk);
            if (w == ar_wait) arready = 1'b1;
            #1;
            chk("arvalid", arvalid, 1);
            chk("araddr", araddr, addr);
            chk("rdy_addr", {inst_rd_rdy, data_rd_rdy}, 0);
            chk("rready_addr", rready, 0);
            if (w == 0) begin
                chk("arid", arid, own ? 4'd1 : 4'd0);
                chk("arlen", arlen, elen);
                chk("arsize", arsize, esize);
                chk("arburst", arburst, 2'b01);
            end
        end
        @(posedge clk); #1;
        arready = 1'b0;
        rid = own ? 4'd1 : 4'd0;
        for (int b = 0; b < nb; b++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                rvalid = 1'b0; rlast = 1'b0; rdata = $urandom;
                #1;
                chk("rready_gap", rready, 1);
                chk("arvalid_data", arvalid, 0);
                chk("ret_valid_gap", {inst_ret_valid, data_ret_valid}, 0);
            end
            @(negedge clk);
            rvalid = 1'b1; rlast = (b == nb - 1); rdata = base * (b + 1);
            #1;
            chk("rready_beat", rready, 1);
            chk("own_valid", own ? data_ret_valid : inst_ret_valid, 1);
            chk("oth_valid", own ? inst_ret_valid : data_ret_valid, 0);
            chk("own_data", own ? data_ret_data : inst_ret_data, base * (b + 1));
            chk("own_last", own ? data_ret_last : inst_ret_last, (b == nb - 1));
            @(posedge clk); #1;
            rvalid = 1'b0; rlast = 1'b0;
        end
`ifdef AXI_ARB_RR_EN
        model_ptr = ~own;
`endif
        @(negedge clk); #1;
        oth_req = own ? inst_rd_req : data_rd_req;
        chk("rready_done", rready, 0);
        chk("arvalid_done", arvalid, 0);
        chk("oth_rdy_done", own ? inst_rd_rdy : data_rd_rdy, oth_req);
    endtask

    typedef struct {
        bit          own;
        logic [2:0]  typ;
        logic [31:0] addr;
        int          ar_wait;
        int          gap;
        logic [31:0] base;
        logic [7:0]  elen;
        logic [2:0]  esize;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit          w;
        bit          both;
        logic [2:0]  t0, t1;
        logic [31:0] a0, a1;
        logic [2:0]  types[4];

        vecs[0] = '{1'b0, 3'b100, 32'hbfc0_0000, 0, 0, 32'h11,        8'd3, 3'd2};
        vecs[1] = '{1'b1, 3'b000, 32'h1faf_0003, 0, 0, 32'hcafe_0001, 8'd0, 3'd0};
        vecs[2] = '{1'b1, 3'b001, 32'h0000_1002, 1, 0, 32'h0000_5a5a, 8'd0, 3'd1};
        vecs[3] = '{1'b1, 3'b010, 32'h8000_0010, 0, 2, 32'h1234_5678, 8'd0, 3'd2};
        vecs[4] = '{1'b0, 3'b100, 32'h0040_0020, 5, 0, 32'h0101_0101, 8'd3, 3'd2};
        vecs[5] = '{1'b1, 3'b100, 32'h2000_0040, 0, 2, 32'h0000_0abc, 8'd3, 3'd2};
        vecs[6] = '{1'b0, 3'b010, 32'hbfc0_0004, 2, 1, 32'h0f0f_0f0f, 8'd0, 3'd2};
        types[0] = 3'b000; types[1] = 3'b001; types[2] = 3'b010; types[3] = 3'b100;

        // Reset state, with a request pending to show rd_rdy is held low
        data_rd_req = 1'b1;
        #3;
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_rdy", {inst_rd_rdy, data_rd_rdy}, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arid", arid, 0);
        chk("rst_ret", {inst_ret_valid, data_ret_valid, inst_ret_last, data_ret_last}, 0);
        data_rd_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Simultaneous inst line and data word; arready withheld 5 cycles for the winner
        w = model_winner();
        if (w)
            do_txn(1'b1, 3'b010, 32'h0000_0800, 8'd0, 3'd2, 5, 0, 32'h0d0d_0001, 1'b0,
                   1'b1, 3'b100, 32'hbfc0_0100);
        else
            do_txn(1'b0, 3'b100, 32'hbfc0_0100, 8'd3, 3'd2, 5, 0, 32'h0e0e_0001, 1'b0,
                   1'b1, 3'b010, 32'h0000_0800);
        if (w)
            do_txn(1'b0, 3'b100, 32'hbfc0_0100, 8'd3, 3'd2, 0, 0, 32'h0e0e_0001, 1'b1,
                   1'b0, 3'b000, 32'h0);
        else
            do_txn(1'b1, 3'b010, 32'h0000_0800, 8'd0, 3'd2, 0, 0, 32'h0d0d_0001, 1'b1,
                   1'b0, 3'b000, 32'h0);

        for (int i = 0; i < 7; i++)
            do_txn(vecs[i].own, vecs[i].typ, vecs[i].addr, vecs[i].elen, vecs[i].esize,
                   vecs[i].ar_wait, vecs[i].gap, vecs[i].base, 1'b0, 1'b0, 3'b000, 32'h0);

        // Reset after 2 of 4 beats, with a data request waiting
        @(negedge clk);
        inst_rd_req = 1'b1; inst_rd_type = 3'b100; inst_rd_addr = 32'hbfc0_0200;
        @(posedge clk); #1;
        inst_rd_req = 1'b0;
        @(negedge clk);
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            rvalid = 1'b1; rlast = 1'b0; rdata = 32'h100 + b;
            @(posedge clk); #1;
        end
        @(negedge clk);
        rdata = 32'h0000_0102;
        data_rd_req = 1'b1; data_rd_type = 3'b010; data_rd_addr = 32'h0000_0c00;
        #1;
        chk("pre_rst_valid", inst_ret_valid, 1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_arvalid", arvalid, 0);
        chk("mid_rst_rready", rready, 0);
        chk("mid_rst_ret_valid", {inst_ret_valid, data_ret_valid}, 0);
        chk("mid_rst_ret_data", inst_ret_data, 0);
        chk("mid_rst_rdy", {inst_rd_rdy, data_rd_rdy}, 0);
        chk("mid_rst_araddr", araddr, 0);
        rvalid = 1'b0;
        model_ptr = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        do_txn(1'b1, 3'b010, 32'h0000_0c00, 8'd0, 3'd2, 0, 0, 32'h7777_0001, 1'b1,
               1'b0, 3'b000, 32'h0);

        // Randomized traffic against the arbitration model
        for (int n = 0; n < 40; n++) begin
            both = $urandom_range(0, 2) == 0;
            t0 = types[$urandom_range(0, 3)];
            t1 = types[$urandom_range(0, 3)];
            a0 = $urandom;
            a1 = $urandom;
            if (both) begin
                w = model_winner();
                do_txn(w, t0, a0, exp_len(t0), exp_size(t0), $urandom_range(0, 3),
                       $urandom_range(0, 2), $urandom, 1'b0, 1'b1, t1, a1);
                do_txn(~w, t1, a1, exp_len(t1), exp_size(t1), $urandom_range(0, 3),
                       $urandom_range(0, 2), $urandom, 1'b1, 1'b0, 3'b000, 32'h0);
            end else begin
                do_txn($urandom_range(0, 1) == 1, t0, a0, exp_len(t0), exp_size(t0),
                       $urandom_range(0, 3), $urandom_range(0, 2), $urandom, 1'b0,
                       1'b0, 3'b000, 32'h0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
